mux_scan_nx1: RTL and testbench
===============================

Name: mux_scan_nx1

Overview:
Parametrised N-channel, W-bit registered multiplexer with a built-in time-division scanner. It is the successor of the fixed 2x1 4-bit selector. It drives the multiplexed digit bus of the timer display: in scan mode it steps through the channels at a prescaled rate, and in manual mode it follows an external select. Output data and a one-hot channel strobe are registered and aligned to each other.

Parameters:
WIDTH, 4, bits per channel
CHANNELS, 4, number of input channels (>=2; non-power-of-2 allowed)
SEL_W, 2, select/index width; must satisfy 2**SEL_W >= CHANNELS
PRESCALE, 50000, clk cycles per scan step (>=1)

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
data_in  input  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH]
mode  input  1  0 = manual select, 1 = auto scan
sel_manual  input  SEL_W  channel index used in manual mode
hold  input  1  1 = freeze index and prescaler (outputs keep tracking data of frozen channel)
data_out  output  WIDTH  registered selected channel data
chan_onehot  output  CHANNELS  registered one-hot of current index, aligned with data_out
chan_idx  output  SEL_W  registered current index
step  output  1  one-cycle pulse when the index changes

Behaviour:
- Reset, asynchronous and active-low: idx=0, prescaler=0, data_out=0, chan_onehot=0, chan_idx=0, step=0. On the first clock after release, the outputs present channel 0: chan_onehot=1, data_out=data_in[0 +: WIDTH].
- Output path: a single register stage. On every clock, data_out <= slice(idx_next), chan_onehot <= 1<<idx_next, chan_idx <= idx_next. The outputs therefore reflect the new index in the same cycle as step, which gives 1-cycle latency from a data_in change to data_out.
- Prescaler, when mode=1 and hold=0: counts 0..PRESCALE-1. At terminal count it wraps to 0 and the scan index advances.
- Scan advance: idx_next = (idx == CHANNELS-1) ? 0 : idx+1. Wrap is explicit, so there is no modulo-2**SEL_W wrap.
- Manual mode (mode=0, hold=0): idx_next = sel_manual if sel_manual < CHANNELS, else CHANNELS-1 (clamp). The prescaler is held at 0.
- hold=1 has priority over both modes: idx, prescaler and step are frozen (step=0). data_out still re-registers the frozen channel's current data.
- Mode change manual->scan: the prescaler restarts from 0. Scanning starts from the current idx, and the first advance occurs PRESCALE cycles later.
- Mode change scan->manual: takes effect on the next clock, and the prescaler clears.
- step=1 for exactly one cycle whenever idx_next != idx. This applies to a scan advance and to a change of manual selection. A manual re-select of the same index gives no pulse.
- PRESCALE=1: the index advances every cycle and step stays high continuously while scanning.
- Reset asserted mid-scan: everything returns to the reset values immediately, independent of clk.
- chan_onehot is always exactly one-hot after the first post-reset clock. It is never all-zero and never multi-hot.

Test Plan:
- Reset/init (CHANNELS=3, PRESCALE=4, WIDTH=4; data_in = {4'hC,4'hB,4'hA}, mode=1): hold rst_n low -> all outputs 0. Release -> next clk gives data_out=A, onehot=3'b001, idx=0.
- Scan wrap (same config): run 12 cycles -> idx sequence 0,1,2,0 with a change every 4 clks, data_out A,B,C,A, and a one-cycle step pulse at each change. idx never reaches 3.
- Manual select and clamp: mode=0, sel_manual=1 -> next clk data_out=B, onehot=010, step=1 once. sel_manual=3 (out of range) -> idx=2, data_out=C. Holding sel_manual=3 -> no further step.
- Hold: while scanning at idx=1, hold=1 for 10 clks -> idx stays 1 and step=0. Change channel 1 data to 4'h7 -> data_out=7 one clk later. Release hold -> advance after the remaining prescale count.
- Mode switch: manual idx=2 -> mode=1 -> exactly 4 clks later idx=0 (wrap), step pulses.
- Async reset mid-scan: drop rst_n between clock edges at idx=2 -> outputs go to 0 without waiting for a clock edge. After release, the scan restarts from channel 0.

Source files
------------

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: N-channel registered mux with prescaled auto-scan and clamped manual select.
// Data, one-hot strobe and index share one register stage so they stay aligned with step.
module mux_scan_nx1 #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int PRESCALE = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_manual,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [CHANNELS-1:0]       chan_onehot,
  output logic [SEL_W-1:0]          chan_idx,
  output logic                      step
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);
  localparam logic [PW-1:0] PTC = PW'(PRESCALE - 1);
  logic [WIDTH-1:0] ch [2**SEL_W];
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc;
  // Unused select codes map to zero so the index always addresses a full-size table.
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
    if (k < CHANNELS) begin : g_in
      assign ch[k] = data_in[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch[k] = '0;
    end
  end
  assign tc       = pre_q == PTC;
  assign chan_idx = idx_q;
  always_comb begin
    pre_d = hold ? pre_q : (mode && !tc) ? pre_q + 1'b1 : '0;
    idx_d = hold ? idx_q
          : mode ? (tc ? (idx_q == LAST ? '0 : idx_q + 1'b1) : idx_q)
          : (sel_manual > LAST ? LAST : sel_manual);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      pre_q       <= '0;
      data_out    <= '0;
      chan_onehot <= '0;
      step        <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      pre_q       <= pre_d;
      data_out    <= ch[idx_d];
      chan_onehot <= CHANNELS'(1) << idx_d;
      step        <= idx_d != idx_q;
    end
  end
endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: table-driven directed cycles plus randomized run against a cycle-count model.
module tb_mux_scan_nx1;
  localparam int W = 4, CH = 3, SW = 2, PS = 4;
  logic clk = 0, rst_n = 0, mode = 1, hold = 0;
  logic [CH*W-1:0] din = 12'hCBA;
  logic [SW-1:0] sel = 0;
  logic [W-1:0] dout, dout1;
  logic [CH-1:0] oh, oh1;
  logic [SW-1:0] idx, idx1;
  logic stp, stp1;
  int checks = 0, errors = 0;
  int m_idx = 0, m_cnt = 0, e_step = 0;

  mux_scan_nx1 #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .PRESCALE(PS)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(din), .mode(mode), .sel_manual(sel), .hold(hold),
    .data_out(dout), .chan_onehot(oh), .chan_idx(idx), .step(stp));
  mux_scan_nx1 #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .mode(mode), .sel_manual(sel), .hold(hold),
    .data_out(dout1), .chan_onehot(oh1), .chan_idx(idx1), .step(stp1));

  always #5 clk = ~clk;

  typedef struct {
    bit mode; bit [1:0] sel; bit hold; bit [11:0] din;
    int idx; bit [3:0] dat; bit stp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit m, input bit [1:0] s, input bit h, input bit [11:0] d,
                     input int i, input bit [3:0] dt, input bit st);
    vec_t v;
    v = '{m, s, h, d, i, dt, st};
    tbl.push_back(v);
  endtask

  // Model: the scan index moves once every PS scanning cycles; manual clamps to the last channel.
  task automatic tick();
    int prev;
    @(posedge clk);
    prev = m_idx;
    if (!hold) begin
      if (mode) begin
        m_cnt++;
        if (m_cnt == PS) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % CH;
        end
      end else begin
        m_cnt = 0;
        m_idx = (int'(sel) >= CH) ? CH - 1 : int'(sel);
      end
    end
    e_step = (m_idx != prev) ? 1 : 0;
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_idx"}, idx, m_idx);
    chk({tag, "_data"}, dout, int'((din >> (m_idx * W)) & 12'hF));
    chk({tag, "_onehot"}, oh, 1 << m_idx);
    chk({tag, "_step"}, stp, e_step);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) add(1, 0, 0, 12'hCBA, 0, 4'hA, 0);
    add(1, 0, 0, 12'hCBA, 1, 4'hB, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 12'hCBA, 1, 4'hB, 0);
    add(1, 0, 0, 12'hCBA, 2, 4'hC, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 12'hCBA, 2, 4'hC, 0);
    add(1, 0, 0, 12'hCBA, 0, 4'hA, 1);
    add(0, 1, 0, 12'hCBA, 1, 4'hB, 1);
    add(0, 1, 0, 12'hCBA, 1, 4'hB, 0);
    add(0, 3, 0, 12'hCBA, 2, 4'hC, 1);
    add(0, 3, 0, 12'hCBA, 2, 4'hC, 0);
    add(0, 3, 0, 12'hCBA, 2, 4'hC, 0);
    for (int i = 0; i < 3; i++) add(1, 3, 0, 12'hCBA, 2, 4'hC, 0);
    add(1, 3, 0, 12'hCBA, 0, 4'hA, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 12'hCBA, 0, 4'hA, 0);
    add(1, 0, 0, 12'hCBA, 1, 4'hB, 1);
    add(1, 0, 0, 12'hCBA, 1, 4'hB, 0);
    add(1, 0, 1, 12'hCBA, 1, 4'hB, 0);
    add(1, 0, 1, 12'hC7A, 1, 4'h7, 0);
    add(1, 0, 1, 12'hC7A, 1, 4'h7, 0);
    add(1, 0, 0, 12'hC7A, 1, 4'h7, 0);
    add(1, 0, 0, 12'hC7A, 1, 4'h7, 0);
    add(1, 0, 0, 12'hC7A, 2, 4'hC, 1);
    add(1, 0, 0, 12'hC7A, 2, 4'hC, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", dout, 0);
    chk("rst_onehot", oh, 0);
    chk("rst_idx", idx, 0);
    chk("rst_step", stp, 0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel; hold = tbl[i].hold; din = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_idx", i), idx, tbl[i].idx);
      chk($sformatf("tbl%0d_data", i), dout, tbl[i].dat);
      chk($sformatf("tbl%0d_onehot", i), oh, 1 << tbl[i].idx);
      chk($sformatf("tbl%0d_step", i), stp, tbl[i].stp);
      if (i < 12) begin
        chk($sformatf("ps1_%0d_idx", i), idx1, (i + 1) % CH);
        chk($sformatf("ps1_%0d_step", i), stp1, 1);
      end
    end

    // Asynchronous reset dropped between edges while at channel 2.
    #2 rst_n = 0;
    #1;
    chk("arst_data", dout, 0);
    chk("arst_onehot", oh, 0);
    chk("arst_idx", idx, 0);
    chk("arst_step", stp, 0);
    @(negedge clk) rst_n = 1;
    m_idx = 0; m_cnt = 0;
    tick();
    chk_model("post_arst");
    chk("post_arst_a", dout, 4'hA);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) mode = ~mode;
      hold = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) sel = SW'($urandom_range(3));
      if ($urandom_range(4) == 0) din = CH*W'($urandom);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
